// File: rtl/qam_rx_ctrl.sv
// QAM receiver control: symbol strobe timing, nibble sync hunt, byte packing
// and a 2-entry AXI-stream output FIFO with a sticky overflow flag.
module qam_rx_ctrl #(
   parameter int unsigned SPS         = 8,
   parameter logic [15:0] SYNC_WORD   = 16'hA5F0,
   parameter int unsigned FRAME_BYTES = 32
) (
   input  logic       axi_clk,
   input  logic       axi_rst,
   input  logic       enable,
   input  logic [7:0] sample_phase,
   input  logic       filter_valid,
   output logic       sym_strobe,
   input  logic       nibble_valid,
   input  logic [3:0] nibble,
   output logic       m_tvalid,
   output logic [7:0] m_tdata,
   output logic       m_tlast,
   input  logic       m_tready,
   output logic       frame_lock,
   output logic       overflow
);

   localparam int               CNT_W     = (SPS > 1) ? $clog2(SPS) : 1;
   localparam logic [CNT_W-1:0] CNT_MAX   = CNT_W'(SPS - 1);
   localparam logic [8:0]       PHASE_MAX = 9'(SPS - 1);
   localparam logic [15:0]      LAST_IDX  = 16'(FRAME_BYTES - 1);

   typedef enum logic [1:0] {IDLE, HUNT, PAYLOAD} state_e;

   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [7:0]       eff_phase;
   logic             sym_strobe_q, sym_strobe_d;

   state_e           state_q, state_d;
   logic [15:0]      win_q, win_d;
   logic [15:0]      win_shift;
   logic             pair_full_q, pair_full_d;
   logic [3:0]       pair_hi_q, pair_hi_d;
   logic [15:0]      byte_cnt_q, byte_cnt_d;
   logic             wr_req;
   logic [8:0]       wr_data;

   logic [8:0]       mem_q [2];
   logic             wr_ptr_q, wr_ptr_d;
   logic             rd_ptr_q, rd_ptr_d;
   logic [1:0]       count_q, count_d;
   logic             overflow_q, overflow_d;
   logic             rd_en, wr_en;

   // NOTE: every variable written here gets a default first, so no path leaves it unassigned and no latch is inferred.
   always_comb begin
      cnt_d        = cnt_q;
      sym_strobe_d = 1'b0;
      eff_phase    = ({1'b0, sample_phase} > PHASE_MAX) ? PHASE_MAX[7:0] : sample_phase;
      if (!enable) begin
         cnt_d = '0;
      end else if (filter_valid) begin
         sym_strobe_d = (8'(cnt_q) == eff_phase);
         cnt_d        = (cnt_q == CNT_MAX) ? '0 : cnt_q + CNT_W'(1);
      end
   end

   assign win_shift = {win_q[11:0], nibble};

   always_comb begin
      state_d     = state_q;
      win_d       = win_q;
      pair_full_d = pair_full_q;
      pair_hi_d   = pair_hi_q;
      byte_cnt_d  = byte_cnt_q;
      wr_req      = 1'b0;
      wr_data     = '0;
      if (!enable) begin
         state_d     = IDLE;
         win_d       = '0;
         pair_full_d = 1'b0;
         pair_hi_d   = '0;
         byte_cnt_d  = '0;
      end else begin
         unique case (state_q)
            IDLE: state_d = HUNT;
            HUNT: begin
               if (nibble_valid) begin
                  win_d = win_shift;
                  if (win_shift == SYNC_WORD) begin
                     state_d     = PAYLOAD;
                     win_d       = '0;
                     byte_cnt_d  = '0;
                     pair_full_d = 1'b0;
                  end
               end
            end
            PAYLOAD: begin
               if (nibble_valid) begin
                  if (!pair_full_q) begin
                     pair_full_d = 1'b1;
                     pair_hi_d   = nibble;
                  end else begin
                     pair_full_d = 1'b0;
                     wr_req      = 1'b1;
                     wr_data     = {byte_cnt_q == LAST_IDX, pair_hi_q, nibble};
                     // Dropped bytes still count, so the frame keeps its length.
                     if (byte_cnt_q == LAST_IDX) begin
                        state_d    = HUNT;
                        byte_cnt_d = '0;
                     end else begin
                        byte_cnt_d = byte_cnt_q + 16'd1;
                     end
                  end
               end
            end
            default: state_d = IDLE;
         endcase
      end
   end

   // A full FIFO still accepts a write when its head leaves in the same cycle.
   assign rd_en = (count_q != 2'd0) && m_tready;
   assign wr_en = wr_req && ((count_q != 2'd2) || rd_en);

   always_comb begin
      wr_ptr_d   = wr_ptr_q ^ wr_en;
      rd_ptr_d   = rd_ptr_q ^ rd_en;
      overflow_d = overflow_q | (wr_req & ~wr_en);
      count_d    = count_q;
      unique case ({wr_en, rd_en})
         2'b10:   count_d = count_q + 2'd1;
         2'b01:   count_d = count_q - 2'd1;
         default: count_d = count_q;
      endcase
   end

   // NOTE: state uses non-blocking assignments so every flop samples the pre-edge values.
   always_ff @(posedge axi_clk or posedge axi_rst) begin
      if (axi_rst) begin
         cnt_q        <= '0;
         sym_strobe_q <= 1'b0;
         state_q      <= IDLE;
         win_q        <= '0;
         pair_full_q  <= 1'b0;
         pair_hi_q    <= '0;
         byte_cnt_q   <= '0;
         wr_ptr_q     <= 1'b0;
         rd_ptr_q     <= 1'b0;
         count_q      <= '0;
         overflow_q   <= 1'b0;
      end else begin
         cnt_q        <= cnt_d;
         sym_strobe_q <= sym_strobe_d;
         state_q      <= state_d;
         win_q        <= win_d;
         pair_full_q  <= pair_full_d;
         pair_hi_q    <= pair_hi_d;
         byte_cnt_q   <= byte_cnt_d;
         wr_ptr_q     <= wr_ptr_d;
         rd_ptr_q     <= rd_ptr_d;
         count_q      <= count_d;
         overflow_q   <= overflow_d;
      end
   end

   // NOTE: FIFO storage is not reset; the outputs are gated by m_tvalid, so stale entries are never visible.
   always_ff @(posedge axi_clk) begin
      if (wr_en) mem_q[wr_ptr_q] <= wr_data;
   end

   assign sym_strobe = sym_strobe_q;
   assign m_tvalid   = (count_q != 2'd0);
   assign m_tdata    = m_tvalid ? mem_q[rd_ptr_q][7:0] : 8'h00;
   assign m_tlast    = m_tvalid & mem_q[rd_ptr_q][8];
   assign frame_lock = (state_q == PAYLOAD);
   assign overflow   = overflow_q;

endmodule

// File: tb/tb_qam_rx_ctrl.sv
// Directed bench for qam_rx_ctrl: a per-cycle vector table for strobe timing
// and sync hunting, then hand sequences for payload, backpressure, enable and reset.
module tb_qam_rx_ctrl;

   logic       axi_clk      = 1'b0;
   logic       axi_rst      = 1'b1;
   logic       enable       = 1'b0;
   logic [7:0] sample_phase = 8'd0;
   logic       filter_valid = 1'b0;
   logic       nibble_valid = 1'b0;
   logic [3:0] nibble       = 4'd0;
   logic       m_tready     = 1'b0;
   logic       sym_strobe;
   logic       m_tvalid;
   logic [7:0] m_tdata;
   logic       m_tlast;
   logic       frame_lock;
   logic       overflow;

   int n_checks = 0;
   int n_errors = 0;

   typedef struct {
      logic       en;
      logic [7:0] ph;
      logic       fv;
      logic       nv;
      logic [3:0] nib;
      logic       exp_stb;
      logic       exp_lock;
   } vec_t;

   vec_t vq[$];

   qam_rx_ctrl #(.SPS(8), .SYNC_WORD(16'hA5F0), .FRAME_BYTES(32)) dut (
      .axi_clk      (axi_clk),
      .axi_rst      (axi_rst),
      .enable       (enable),
      .sample_phase (sample_phase),
      .filter_valid (filter_valid),
      .sym_strobe   (sym_strobe),
      .nibble_valid (nibble_valid),
      .nibble       (nibble),
      .m_tvalid     (m_tvalid),
      .m_tdata      (m_tdata),
      .m_tlast      (m_tlast),
      .m_tready     (m_tready),
      .frame_lock   (frame_lock),
      .overflow     (overflow)
   );

   always #5 axi_clk = ~axi_clk;

   task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge axi_clk);
      #1;
   endtask

   task automatic send_nib(input logic [3:0] n);
      nibble_valid = 1'b1;
      nibble       = n;
      step();
      nibble_valid = 1'b0;
   endtask

   task automatic send_sync();
      send_nib(4'hA);
      send_nib(4'h5);
      send_nib(4'hF);
      send_nib(4'h0);
      check("lock_after_sync", 16'(frame_lock), 16'd1);
   endtask

   task automatic add(input logic en, input logic [7:0] ph, input logic fv, input logic nv,
                      input logic [3:0] nib, input logic stb, input logic lk);
      vec_t v;
      v.en = en; v.ph = ph; v.fv = fv; v.nv = nv; v.nib = nib; v.exp_stb = stb; v.exp_lock = lk;
      vq.push_back(v);
   endtask

   initial begin
      logic [7:0] exp_b;

      // Strobe timing: phase 3 fires after counter 3; phase 200 clamps to 7.
      for (int k = 0; k < 12; k++) add(1'b1, 8'd3, 1'b1, 1'b0, 4'h0, (k == 3 || k == 11), 1'b0);
      add(1'b1, 8'd3,   1'b0, 1'b0, 4'h0, 1'b0, 1'b0);
      add(1'b1, 8'd200, 1'b1, 1'b0, 4'h0, 1'b0, 1'b0);
      add(1'b1, 8'd200, 1'b1, 1'b0, 4'h0, 1'b0, 1'b0);
      add(1'b1, 8'd200, 1'b1, 1'b0, 4'h0, 1'b0, 1'b0);
      add(1'b1, 8'd200, 1'b1, 1'b0, 4'h0, 1'b1, 1'b0);
      add(1'b1, 8'd200, 1'b1, 1'b0, 4'h0, 1'b0, 1'b0);
      add(1'b1, 8'd0,   1'b0, 1'b0, 4'h0, 1'b0, 1'b0);
      add(1'b1, 8'd1,   1'b1, 1'b0, 4'h0, 1'b1, 1'b0);
      // Near miss A5F1, then A5F0 locks.
      add(1'b1, 8'd0, 1'b0, 1'b1, 4'hA, 1'b0, 1'b0);
      add(1'b1, 8'd0, 1'b0, 1'b1, 4'h5, 1'b0, 1'b0);
      add(1'b1, 8'd0, 1'b0, 1'b1, 4'hF, 1'b0, 1'b0);
      add(1'b1, 8'd0, 1'b0, 1'b1, 4'h1, 1'b0, 1'b0);
      add(1'b1, 8'd0, 1'b0, 1'b1, 4'hA, 1'b0, 1'b0);
      add(1'b1, 8'd0, 1'b0, 1'b1, 4'h5, 1'b0, 1'b0);
      add(1'b1, 8'd0, 1'b0, 1'b1, 4'hF, 1'b0, 1'b0);
      add(1'b1, 8'd0, 1'b0, 1'b1, 4'h0, 1'b0, 1'b1);
      // Disable, then a nibble seen in IDLE must not join the window.
      add(1'b0, 8'd0, 1'b0, 1'b0, 4'h0, 1'b0, 1'b0);
      add(1'b1, 8'd0, 1'b0, 1'b1, 4'hA, 1'b0, 1'b0);
      add(1'b1, 8'd0, 1'b0, 1'b1, 4'h5, 1'b0, 1'b0);
      add(1'b1, 8'd0, 1'b0, 1'b1, 4'hF, 1'b0, 1'b0);
      add(1'b1, 8'd0, 1'b0, 1'b1, 4'h0, 1'b0, 1'b0);
      // Overlapping pattern A,A,5,F,0.
      add(1'b1, 8'd0, 1'b0, 1'b1, 4'hA, 1'b0, 1'b0);
      add(1'b1, 8'd0, 1'b0, 1'b1, 4'hA, 1'b0, 1'b0);
      add(1'b1, 8'd0, 1'b0, 1'b1, 4'h5, 1'b0, 1'b0);
      add(1'b1, 8'd0, 1'b0, 1'b1, 4'hF, 1'b0, 1'b0);
      add(1'b1, 8'd0, 1'b0, 1'b1, 4'h0, 1'b0, 1'b1);

      #12;
      check("rst_sym_strobe", 16'(sym_strobe), 16'd0);
      check("rst_m_tvalid",   16'(m_tvalid),   16'd0);
      check("rst_m_tdata",    16'(m_tdata),    16'd0);
      check("rst_m_tlast",    16'(m_tlast),    16'd0);
      check("rst_frame_lock", 16'(frame_lock), 16'd0);
      check("rst_overflow",   16'(overflow),   16'd0);
      #10;
      axi_rst = 1'b0;

      for (int i = 0; i < vq.size(); i++) begin
         enable       = vq[i].en;
         sample_phase = vq[i].ph;
         filter_valid = vq[i].fv;
         nibble_valid = vq[i].nv;
         nibble       = vq[i].nib;
         step();
         check($sformatf("vec%0d_strobe", i), 16'(sym_strobe), 16'(vq[i].exp_stb));
         check($sformatf("vec%0d_lock", i),   16'(frame_lock), 16'(vq[i].exp_lock));
      end
      filter_valid = 1'b0;
      nibble_valid = 1'b0;
      sample_phase = 8'd0;

      // Full frame with m_tready high: 0x12,0x34,... and m_tlast only on byte 32.
      m_tready = 1'b1;
      check("frame_idle_tvalid", 16'(m_tvalid), 16'd0);
      for (int k = 1; k <= 64; k++) begin
         send_nib(4'(k));
         if (k % 2 == 0) begin
            exp_b = {4'(k - 1), 4'(k)};
            check($sformatf("frame_b%0d_tvalid", k / 2), 16'(m_tvalid), 16'd1);
            check($sformatf("frame_b%0d_tdata", k / 2),  16'(m_tdata),  16'(exp_b));
            check($sformatf("frame_b%0d_tlast", k / 2),  16'(m_tlast),  16'(k == 64));
         end else begin
            check($sformatf("frame_n%0d_tvalid", k), 16'(m_tvalid), 16'd0);
         end
         check($sformatf("frame_n%0d_lock", k), 16'(frame_lock), 16'(k != 64));
      end
      step();
      check("frame_end_tvalid", 16'(m_tvalid),   16'd0);
      check("frame_end_lock",   16'(frame_lock), 16'd0);

      // Back-pressure for a whole frame: two bytes held, the rest dropped.
      m_tready = 1'b0;
      send_sync();
      for (int k = 1; k <= 64; k++) begin
         send_nib(4'(k));
         if (k >= 2) begin
            check($sformatf("bp_n%0d_tvalid", k), 16'(m_tvalid), 16'd1);
            check($sformatf("bp_n%0d_tdata", k),  16'(m_tdata),  16'h12);
         end
         check($sformatf("bp_n%0d_overflow", k), 16'(overflow), 16'(k >= 6));
      end
      check("bp_lock",  16'(frame_lock), 16'd0);
      check("bp_tlast", 16'(m_tlast),    16'd0);
      m_tready = 1'b1;
      step();
      check("bp_drain1_tvalid", 16'(m_tvalid), 16'd1);
      check("bp_drain1_tdata",  16'(m_tdata),  16'h34);
      step();
      check("bp_drain2_tvalid", 16'(m_tvalid), 16'd0);
      check("bp_overflow_sticky", 16'(overflow), 16'd1);

      // Enable dropped mid-payload: IDLE, then HUNT; queued byte still drains.
      m_tready = 1'b0;
      send_sync();
      send_nib(4'h7);
      send_nib(4'h8);
      check("en_byte_tdata", 16'(m_tdata), 16'h78);
      send_nib(4'h9);
      enable = 1'b0;
      step();
      check("en_off_lock",   16'(frame_lock), 16'd0);
      check("en_off_tvalid", 16'(m_tvalid),   16'd1);
      check("en_off_tdata",  16'(m_tdata),    16'h78);
      enable = 1'b1;
      step();
      check("en_on_lock", 16'(frame_lock), 16'd0);
      send_nib(4'h1);
      send_nib(4'h2);
      check("en_nosync_lock",  16'(frame_lock), 16'd0);
      check("en_nosync_tdata", 16'(m_tdata),    16'h78);
      m_tready = 1'b1;
      step();
      check("en_drain_tvalid", 16'(m_tvalid), 16'd0);
      send_sync();
      send_nib(4'h3);
      send_nib(4'h4);
      check("en_resync_tvalid", 16'(m_tvalid), 16'd1);
      check("en_resync_tdata",  16'(m_tdata),  16'h34);
      check("en_resync_tlast",  16'(m_tlast),  16'd0);
      step();
      check("en_resync_drain", 16'(m_tvalid), 16'd0);

      // Asynchronous reset between edges while a byte is presented.
      m_tready = 1'b0;
      send_nib(4'h5);
      send_nib(4'h6);
      send_nib(4'h7);
      send_nib(4'h8);
      send_nib(4'h9);
      send_nib(4'hA);
      check("pre_rst_tdata",    16'(m_tdata),  16'h56);
      check("pre_rst_overflow", 16'(overflow), 16'd1);
      #3;
      axi_rst = 1'b1;
      #1;
      check("arst_sym_strobe", 16'(sym_strobe), 16'd0);
      check("arst_m_tvalid",   16'(m_tvalid),   16'd0);
      check("arst_m_tdata",    16'(m_tdata),    16'd0);
      check("arst_m_tlast",    16'(m_tlast),    16'd0);
      check("arst_frame_lock", 16'(frame_lock), 16'd0);
      check("arst_overflow",   16'(overflow),   16'd0);
      step();
      check("arst_held_tvalid", 16'(m_tvalid), 16'd0);
      #2;
      axi_rst = 1'b0;
      step();

      // Write and read in the same cycle with the FIFO full is not an overflow.
      send_sync();
      send_nib(4'h1);
      send_nib(4'h2);
      send_nib(4'h3);
      send_nib(4'h4);
      check("full_tdata", 16'(m_tdata), 16'h12);
      send_nib(4'h5);
      m_tready = 1'b1;
      send_nib(4'h6);
      check("rw_overflow", 16'(overflow), 16'd0);
      check("rw_tvalid",   16'(m_tvalid), 16'd1);
      check("rw_tdata",    16'(m_tdata),  16'h34);
      step();
      check("rw_next_tdata", 16'(m_tdata), 16'h56);
      step();
      check("rw_empty_tvalid", 16'(m_tvalid), 16'd0);
      check("rw_end_overflow", 16'(overflow), 16'd0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
